// File: rtl/mttkrp_pkg.sv
// Shared types and constants for the MTTKRP factor-row fetch path.
package mttkrp_pkg;

  localparam int DEF_RANK_FACTOR_MATRIX  = 16;
  localparam int DEF_FACTOR_MATRIX_WIDTH = 32;

  typedef logic [DEF_RANK_FACTOR_MATRIX*DEF_FACTOR_MATRIX_WIDTH-1:0] factor_row_t;

  // Cycles from request acceptance to the response being visible.
  localparam int FRS_READ_LATENCY = 3;

  function automatic int compute_id_width(input int num_compute_units);
    return $clog2(num_compute_units) + 1;
  endfunction

endpackage

// File: rtl/factor_bank.sv
// One factor-matrix bank: simple dual-port RAM with a registered read
// address and a registered read output.
module factor_bank
  import mttkrp_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024,
  localparam int BAW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [BAW-1:0]    wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [BAW-1:0]    rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [BAW-1:0]    rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_addr_d = rd_en ? rd_addr : rd_addr_q;
    rd_data_d = mem_q[rd_addr_q];
  end

  // Storage carries no reset so bank contents survive a block reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_addr_q <= rd_addr_d;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/factor_row_server.sv
// Responder for PE factor-row fetches: queues tagged per-mode row requests
// and returns the rows from per-mode factor banks in request order.
module factor_row_server
  import mttkrp_pkg::*;
#(
  parameter int TENSOR_DIMENSIONS      = 4,
  parameter int FACTOR_MATRIX_WIDTH    = 32,
  parameter int RANK_FACTOR_MATRIX     = 16,
  parameter int MODE_TENSOR_ADDR_WIDTH = 16,
  parameter int NUM_FACTOR_ROWS        = 1024,
  parameter int NUM_COMPUTE_UNITS      = 320,
  parameter int REQ_FIFO_DEPTH         = 8,
  localparam int NM    = TENSOR_DIMENSIONS - 1,
  localparam int RW    = $clog2(NUM_FACTOR_ROWS),
  localparam int AW    = MODE_TENSOR_ADDR_WIDTH,
  localparam int ROW_W = RANK_FACTOR_MATRIX * FACTOR_MATRIX_WIDTH,
  localparam int ID_W  = compute_id_width(NUM_COMPUTE_UNITS),
  localparam int WM_W  = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NM-1:0]       req_addr_en,
  input  logic [NM*AW-1:0]    req_addr,
  input  logic [ID_W-1:0]     req_compute_id,
  output logic                req_ready,
  input  logic                wr_en,
  input  logic [WM_W-1:0]     wr_mode,
  input  logic [RW-1:0]       wr_addr,
  input  logic [ROW_W-1:0]    wr_data,
  output logic [NM-1:0]       resp_en,
  output logic [NM*ROW_W-1:0] resp_data,
  output logic [ID_W-1:0]     resp_compute_id,
  output logic                factor_data_ack,
  output logic                overflow,
  output logic                addr_err
);

  localparam int ENT_W = NM + NM*AW + ID_W;
  localparam int PW    = $clog2(REQ_FIFO_DEPTH);
  localparam int CW    = PW + 1;

  logic [ENT_W-1:0] fifo_q [REQ_FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q, ready_d;
  logic             overflow_q, overflow_d;
  logic             addr_err_q, addr_err_d;
  logic [NM-1:0]    s1_en_q, s1_en_d, s1_ok_q, s1_ok_d;
  logic [NM-1:0]    s2_en_q, s2_en_d, s2_ok_q, s2_ok_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d, s2_id_q, s2_id_d;

  logic             req_any, accept, push, pop, full;
  logic [NM-1:0]    head_en, head_oor;
  logic [NM*AW-1:0] head_addr;
  logic [ID_W-1:0]  head_id;
  logic [NM*ROW_W-1:0] bank_rdata;

  assign {head_en, head_addr, head_id} = fifo_q[rd_ptr_q];

  for (genvar m = 0; m < NM; m++) begin : g_mode
    logic [AW-1:0] lane_addr;
    assign lane_addr = head_addr[m*AW +: AW];

    if (AW > RW) begin : g_oor
      assign head_oor[m] = |lane_addr[AW-1:RW];
    end else begin : g_no_oor
      assign head_oor[m] = 1'b0;
    end

    factor_bank #(
      .DATA_W (ROW_W),
      .DEPTH  (NUM_FACTOR_ROWS)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_en && (int'(wr_mode) == m)),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_addr (lane_addr[RW-1:0]),
      .rd_data (bank_rdata[m*ROW_W +: ROW_W])
    );

    assign resp_data[m*ROW_W +: ROW_W] = s2_ok_q[m] ? bank_rdata[m*ROW_W +: ROW_W] : '0;
  end

  always_comb begin
    req_any = |req_addr_en;
    full    = (count_q == CW'(REQ_FIFO_DEPTH));
    accept  = req_any && ready_q;
    push    = accept && !full;
    // A bank write owns the whole cycle, so it stalls the pop.
    pop     = (count_q != '0) && !wr_en;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // One slot stays free for the request that lands while ready updates.
    ready_d = (count_d < CW'(REQ_FIFO_DEPTH - 1));

    overflow_d = overflow_q | (req_any && !ready_q) | (accept && full);
    addr_err_d = addr_err_q | (pop && |(head_en & head_oor));

    s1_en_d = pop ? head_en : '0;
    s1_ok_d = pop ? (head_en & ~head_oor) : '0;
    s1_id_d = pop ? head_id : '0;
    s2_en_d = s1_en_q;
    s2_ok_d = s1_ok_q;
    s2_id_d = s1_id_q;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {req_addr_en, req_addr, req_compute_id};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
      s1_en_q    <= '0;
      s1_ok_q    <= '0;
      s1_id_q    <= '0;
      s2_en_q    <= '0;
      s2_ok_q    <= '0;
      s2_id_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      addr_err_q <= addr_err_d;
      s1_en_q    <= s1_en_d;
      s1_ok_q    <= s1_ok_d;
      s1_id_q    <= s1_id_d;
      s2_en_q    <= s2_en_d;
      s2_ok_q    <= s2_ok_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign req_ready       = ready_q;
  assign resp_en         = s2_en_q;
  assign resp_compute_id = s2_id_q;
  assign factor_data_ack = |s2_en_q;
  assign overflow        = overflow_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_factor_row_server.sv
// Randomized scoreboard bench for factor_row_server against a queue-based
// reference model of the request FIFO and factor banks.
module tb_factor_row_server;
  import mttkrp_pkg::*;

  localparam int NM    = 3;
  localparam int AW    = 16;
  localparam int ROW_W = 512;
  localparam int ID_W  = 10;
  localparam int NROWS = 1024;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NM-1:0]       req_addr_en = '0;
  logic [NM*AW-1:0]    req_addr = '0;
  logic [ID_W-1:0]     req_compute_id = '0;
  logic                req_ready;
  logic                wr_en = 1'b0;
  logic [1:0]          wr_mode = '0;
  logic [9:0]          wr_addr = '0;
  logic [ROW_W-1:0]    wr_data = '0;
  logic [NM-1:0]       resp_en;
  logic [NM*ROW_W-1:0] resp_data;
  logic [ID_W-1:0]     resp_compute_id;
  logic                factor_data_ack;
  logic                overflow;
  logic                addr_err;

  always #5 clk = ~clk;

  factor_row_server dut (
    .clk             (clk),
    .rst             (rst),
    .req_addr_en     (req_addr_en),
    .req_addr        (req_addr),
    .req_compute_id  (req_compute_id),
    .req_ready       (req_ready),
    .wr_en           (wr_en),
    .wr_mode         (wr_mode),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .resp_en         (resp_en),
    .resp_data       (resp_data),
    .resp_compute_id (resp_compute_id),
    .factor_data_ack (factor_data_ack),
    .overflow        (overflow),
    .addr_err        (addr_err)
  );

  typedef struct {
    logic [NM-1:0]    en;
    logic [NM*AW-1:0] addr;
    logic [ID_W-1:0]  id;
  } req_t;

  typedef struct {
    logic [NM-1:0]       en;
    logic [NM*ROW_W-1:0] data;
    logic [ID_W-1:0]     id;
    int                  due;
  } exp_t;

  req_t             mq[$];
  exp_t             sb[$];
  logic [ROW_W-1:0] mem_m [NM][NROWS];
  logic             ready_m = 1'b0;
  logic             ovf_m = 1'b0;
  logic             err_m = 1'b0;
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] seq_row(input logic [31:0] base);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [NM*AW-1:0] mk_addr(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
    return {a2, a1, a0};
  endfunction

  // Reference model: one call per clock cycle with that cycle's inputs.
  task automatic model_step(input logic [NM-1:0] en, input logic [NM*AW-1:0] addr,
                            input logic [ID_W-1:0] id, input logic we, input logic [1:0] wm,
                            input logic [9:0] wa, input logic [ROW_W-1:0] wd);
    req_t r;
    exp_t e;
    logic [15:0] a;
    if (mq.size() > 0 && !we) begin
      r = mq.pop_front();
      e.en = r.en;
      e.id = r.id;
      e.due = cyc + 2;
      e.data = '0;
      for (int m = 0; m < NM; m++) begin
        a = r.addr[m*AW +: AW];
        if (r.en[m]) begin
          if (int'(a) < NROWS) e.data[m*ROW_W +: ROW_W] = mem_m[m][a[9:0]];
          else err_m = 1'b1;
        end
      end
      sb.push_back(e);
    end
    if (we && int'(wm) < NM) mem_m[wm][wa] = wd;
    if (en != '0) begin
      if (ready_m) begin
        r.en = en;
        r.addr = addr;
        r.id = id;
        mq.push_back(r);
      end else begin
        ovf_m = 1'b1;
      end
    end
    ready_m = (mq.size() < DEPTH - 1);
  endtask

  task automatic drive(input logic [NM-1:0] en, input logic [NM*AW-1:0] addr,
                       input logic [ID_W-1:0] id, input logic we, input logic [1:0] wm,
                       input logic [9:0] wa, input logic [ROW_W-1:0] wd);
    @(negedge clk);
    req_addr_en = en;
    req_addr = addr;
    req_compute_id = id;
    wr_en = we;
    wr_mode = wm;
    wr_addr = wa;
    wr_data = wd;
    model_step(en, addr, id, we, wm, wa, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic write_row(input int m, input int row, input logic [ROW_W-1:0] d);
    drive('0, '0, '0, 1'b1, 2'(m), 10'(row), d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_addr_en = '0;
    wr_en = 1'b0;
    mq.delete();
    sb.delete();
    ready_m = 1'b0;
    ovf_m = 1'b0;
    err_m = 1'b0;
    #1;
    chk("rst_resp_en", 32'(resp_en), 32'd0);
    chk("rst_ack", 32'(factor_data_ack), 32'd0);
    chk("rst_id", 32'(resp_compute_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    for (int m = 0; m < NM; m++) chk_row("rst_resp_data", resp_data[m*ROW_W +: ROW_W], '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_step('0, '0, '0, 1'b0, 2'd0, '0, '0);
  endtask

  // Monitor: compares flags every cycle and pops the scoreboard on each response.
  exp_t got;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(ready_m));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("addr_err", 32'(addr_err), 32'(err_m));
      chk("ack_vs_resp_en", 32'(factor_data_ack), 32'(|resp_en));
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_resp id=%0d due=%0d now=%0d", sb[0].id, sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (resp_en != '0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp @cyc %0d: got resp_en=%0b id=%0d expected none",
                   cyc, resp_en, resp_compute_id);
        end else begin
          got = sb.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(got.due));
          chk("resp_en", 32'(resp_en), 32'(got.en));
          chk("resp_id", 32'(resp_compute_id), 32'(got.id));
          for (int m = 0; m < NM; m++)
            chk_row("resp_data", resp_data[m*ROW_W +: ROW_W], got.data[m*ROW_W +: ROW_W]);
        end
      end
    end
  end

  initial begin
    do_reset();
    for (int m = 0; m < NM; m++)
      for (int r = 0; r < 16; r++) write_row(m, r, rand_row());

    // basic read with a masked middle lane
    write_row(0, 5, seq_row(32'h1));
    write_row(2, 7, seq_row(32'hA));
    drive(3'b101, mk_addr(16'd5, 16'd3, 16'd7), 10'd42, 1'b0, 2'd0, '0, '0);
    idle(5);

    // back-to-back
    for (int i = 0; i < 8; i++)
      drive(3'($urandom_range(1, 7)), mk_addr(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
            16'($urandom_range(0, 15))), 10'(i), 1'b0, 2'd0, '0, '0);
    idle(5);

    // fill the FIFO behind ignored writes (mode 3) until ready drops and overflow sets
    for (int i = 0; i < 10; i++)
      drive(3'b111, mk_addr(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
            16'($urandom_range(0, 15))), 10'(100 + i), 1'b1, 2'd3, 10'($urandom_range(0, 15)), rand_row());
    idle(12);

    // write stall and read-after-write
    drive(3'b010, mk_addr(16'd0, 16'd9, 16'd0), 10'd200, 1'b0, 2'd0, '0, '0);
    write_row(1, 9, rand_row());
    write_row(1, 9, rand_row());
    drive(3'b010, mk_addr(16'd0, 16'd9, 16'd0), 10'd201, 1'b0, 2'd0, '0, '0);
    idle(5);

    // out-of-range addresses
    drive(3'b010, mk_addr(16'd3, 16'd1024, 16'd4), 10'd300, 1'b0, 2'd0, '0, '0);
    drive(3'b111, mk_addr(16'd2, 16'hFFFF, 16'd1), 10'd301, 1'b0, 2'd0, '0, '0);
    idle(5);

    // inputs wiggling with no enable
    for (int i = 0; i < 5; i++)
      drive('0, 48'({$urandom(), $urandom()}), 10'($urandom()), 1'b0, 2'd0, '0, '0);
    idle(3);

    // reset with requests in flight, then confirm bank contents survived
    for (int i = 0; i < 3; i++)
      drive(3'b001, mk_addr(16'd5, 16'd0, 16'd0), 10'(400 + i), 1'b0, 2'd0, '0, '0);
    do_reset();
    idle(6);
    drive(3'b101, mk_addr(16'd5, 16'd0, 16'd7), 10'd410, 1'b0, 2'd0, '0, '0);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [NM*AW-1:0] a;
      for (int m = 0; m < NM; m++)
        a[m*AW +: AW] = ($urandom_range(0, 15) == 0) ? 16'(1024 + $urandom_range(0, 60000))
                                                      : 16'($urandom_range(0, 15));
      drive(3'($urandom_range(0, 7)), a, 10'($urandom_range(0, 319)),
            ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), 10'($urandom_range(0, 15)), rand_row());
    end
    idle(15);

    checks++;
    if (sb.size() != 0 || mq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d responses outstanding expected 0", sb.size() + mq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
